race_text_ctrl: RTL and testbench

Game-phase sequencer and font-ROM arbiter for the text overlays in the racing game's VGA path. It decides which overlay is enabled: the "Start" banner, the 3-2-1 countdown, or "Game Over". It blinks the banners on frame ticks. It also shares the single synchronous font ROM between the overlay generators, returning one pipeline-aligned text pixel to the pixel mixer.

---
 rtl/race_text_pkg.sv | 15 +
 rtl/race_text_ctrl_font_arb.sv | 42 ++++
 rtl/race_text_ctrl.sv | 138 +++++++++++++
 tb/tb_race_text_ctrl.sv | 195 +++++++++++++++++++
 4 files changed

// File: rtl/race_text_pkg.sv
// race_text_pkg: shared state encoding, overlay indices and font geometry for the race text overlays
package race_text_pkg;
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    COUNT = 2'd1,
    RUN   = 2'd2,
    OVER  = 2'd3
  } race_state_t;
  localparam int OVL_START = 0;
  localparam int OVL_CNT = 1;
  localparam int OVL_OVER = 2;
  localparam int FONT_ADDR_W = 11;
  localparam int FONT_W = 8;
  localparam int BIT_W = $clog2(FONT_W);
endpackage

// File: rtl/race_text_ctrl_font_arb.sv
// font_arb: fixed-priority font ROM mux with the pixel select delayed to line up with the ROM read
module font_arb
  import race_text_pkg::*;
(
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start_on_i,
  input  logic [FONT_ADDR_W-1:0] start_rom_addr_i,
  input  logic [BIT_W-1:0]       start_bit_addr_i,
  input  logic                   cnt_on_i,
  input  logic [FONT_ADDR_W-1:0] cnt_rom_addr_i,
  input  logic [BIT_W-1:0]       cnt_bit_addr_i,
  input  logic                   over_on_i,
  input  logic [FONT_ADDR_W-1:0] over_rom_addr_i,
  input  logic [BIT_W-1:0]       over_bit_addr_i,
  input  logic [FONT_W-1:0]      rom_data,
  output logic [FONT_ADDR_W-1:0] rom_addr,
  output logic                   text_pix
);
  logic             any_on;
  logic             on_d;
  logic [BIT_W-1:0] bit_addr;
  logic [BIT_W-1:0] bit_addr_d;
  // over beats cnt beats start; idle bus parks at address 0
  always_comb begin
    any_on = over_on_i | cnt_on_i | start_on_i;
    rom_addr = over_on_i ? over_rom_addr_i : cnt_on_i ? cnt_rom_addr_i : start_on_i ? start_rom_addr_i : '0;
    bit_addr = over_on_i ? over_bit_addr_i : cnt_on_i ? cnt_bit_addr_i : start_on_i ? start_bit_addr_i : '0;
  end
  // hold the winner's column for one cycle while the ROM word comes back
  always_ff @(posedge clk) begin
    if (reset) begin
      on_d <= 1'b0;
      bit_addr_d <= '0;
    end else begin
      on_d <= any_on;
      bit_addr_d <= bit_addr;
    end
  end
  // bit 7 of the font word is the leftmost pixel
  assign text_pix = on_d & rom_data[~bit_addr_d];
endmodule

// File: rtl/race_text_ctrl.sv
// race_text_ctrl: game-phase sequencer and font-ROM arbiter for text overlays; blinking enabled by RACE_TEXT_BLINK_EN
module race_text_ctrl
  import race_text_pkg::*;
#(
  parameter int FRAME_RATE = 60,
  parameter int COUNT_SECS = 3,
  parameter int BLINK_FRAMES = 30,
  parameter int OVER_HOLD = 120
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   refr_tick,
  input  logic                   btn_start,
  input  logic                   crash,
  input  logic                   start_on_i,
  input  logic [FONT_ADDR_W-1:0] start_rom_addr_i,
  input  logic [BIT_W-1:0]       start_bit_addr_i,
  input  logic                   cnt_on_i,
  input  logic [FONT_ADDR_W-1:0] cnt_rom_addr_i,
  input  logic [BIT_W-1:0]       cnt_bit_addr_i,
  input  logic                   over_on_i,
  input  logic [FONT_ADDR_W-1:0] over_rom_addr_i,
  input  logic [BIT_W-1:0]       over_bit_addr_i,
  input  logic [FONT_W-1:0]      rom_data,
  output logic [FONT_ADDR_W-1:0] rom_addr,
  output logic                   start_en,
  output logic                   cnt_en,
  output logic                   over_en,
  output logic [1:0]             cnt_digit,
  output logic                   game_run,
  output logic                   text_pix
);
  localparam int FC_MAX = FRAME_RATE > OVER_HOLD ? FRAME_RATE : OVER_HOLD;
  localparam int FC_W = $clog2(FC_MAX) + 1;
  race_state_t     state, state_nx;
  logic [FC_W-1:0] fc, fc_nx;
  logic [1:0]      digit_nx;
  logic            btn_q, rise;
  logic            phase_nx;
  logic            start_en_nx, cnt_en_nx, over_en_nx, game_run_nx;
  assign rise = btn_start & ~btn_q;
  // phase transitions; in COUNT the frame counter measures one second and then wraps
  always_comb begin
    state_nx = state;
    fc_nx = fc;
    digit_nx = cnt_digit;
    case (state)
      IDLE: if (rise) begin
        state_nx = COUNT;
        fc_nx = '0;
        digit_nx = COUNT_SECS[1:0];
      end
      COUNT: if (refr_tick) begin
        if (fc == FC_W'(FRAME_RATE - 1)) begin
          fc_nx = '0;
          digit_nx = cnt_digit - 2'd1;
          if (cnt_digit == 2'd1) state_nx = RUN;
        end else fc_nx = fc + FC_W'(1);
      end
      RUN: if (crash) begin
        state_nx = OVER;
        fc_nx = '0;
      end
      OVER: begin
        if (rise && fc == FC_W'(OVER_HOLD)) state_nx = IDLE;
        else if (refr_tick && fc != FC_W'(OVER_HOLD)) fc_nx = fc + FC_W'(1);
      end
    endcase
  end
`ifdef RACE_TEXT_BLINK_EN
  localparam int BC_W = $clog2(BLINK_FRAMES) + 1;
  logic [BC_W-1:0] bc, bc_nx;
  logic            phase, bc_wrap;
  // blink restarts visible on every state entry
  always_comb begin
    bc_wrap = bc == BC_W'(BLINK_FRAMES - 1);
    bc_nx = state_nx != state ? '0 : refr_tick ? (bc_wrap ? '0 : bc + BC_W'(1)) : bc;
    phase_nx = state_nx != state ? 1'b1 : (refr_tick && bc_wrap) ? ~phase : phase;
  end
  // blink counter and phase registers
  always_ff @(posedge clk) begin
    if (reset) begin
      bc <= '0;
      phase <= 1'b1;
    end else begin
      bc <= bc_nx;
      phase <= phase_nx;
    end
  end
`else
  assign phase_nx = 1'b1;
`endif
  // enables follow the next state so they change together with it
  always_comb begin
    start_en_nx = state_nx == IDLE && phase_nx;
    cnt_en_nx = state_nx == COUNT;
    over_en_nx = state_nx == OVER && phase_nx;
    game_run_nx = state_nx == RUN;
  end
  // state, frame counter, button history and registered outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      fc <= '0;
      cnt_digit <= '0;
      btn_q <= 1'b1;
      start_en <= 1'b1;
      cnt_en <= 1'b0;
      over_en <= 1'b0;
      game_run <= 1'b0;
    end else begin
      state <= state_nx;
      fc <= fc_nx;
      cnt_digit <= digit_nx;
      btn_q <= btn_start;
      start_en <= start_en_nx;
      cnt_en <= cnt_en_nx;
      over_en <= over_en_nx;
      game_run <= game_run_nx;
    end
  end
  font_arb u_arb (
    .clk(clk),
    .reset(reset),
    .start_on_i(start_on_i),
    .start_rom_addr_i(start_rom_addr_i),
    .start_bit_addr_i(start_bit_addr_i),
    .cnt_on_i(cnt_on_i),
    .cnt_rom_addr_i(cnt_rom_addr_i),
    .cnt_bit_addr_i(cnt_bit_addr_i),
    .over_on_i(over_on_i),
    .over_rom_addr_i(over_rom_addr_i),
    .over_bit_addr_i(over_bit_addr_i),
    .rom_data(rom_data),
    .rom_addr(rom_addr),
    .text_pix(text_pix)
  );
endmodule

// File: tb/tb_race_text_ctrl.sv
// tb_race_text_ctrl: directed sequences, arbitration table and random run against a behavioural model
module tb_race_text_ctrl;
  logic clk = 1'b0, reset = 1'b1, refr_tick = 1'b0, btn_start = 1'b0, crash = 1'b0;
  logic start_on_i = 1'b0, cnt_on_i = 1'b0, over_on_i = 1'b0;
  logic [10:0] start_rom_addr_i = '0, cnt_rom_addr_i = '0, over_rom_addr_i = '0;
  logic [2:0] start_bit_addr_i = '0, cnt_bit_addr_i = '0, over_bit_addr_i = '0;
  logic [7:0] rom_data = '0;
  logic [10:0] rom_addr;
  logic start_en, cnt_en, over_en, game_run, text_pix;
  logic [1:0] cnt_digit;
  int n_chk = 0, n_fail = 0;
  int ms = 0, ent = 0, m_bit = 0;
  bit bprev = 1'b1, m_on = 1'b0;
`ifdef RACE_TEXT_BLINK_EN
  localparam bit BLINK = 1'b1;
`else
  localparam bit BLINK = 1'b0;
`endif
  typedef struct {
    logic [2:0] on;
    logic [10:0] sa, ca, oa;
    logic [2:0] sb, cb, ob;
    logic [7:0] rd;
    logic [10:0] ea;
    logic ep;
  } arb_vec_t;
  arb_vec_t tbl[6];

  race_text_ctrl dut (
    .clk(clk), .reset(reset), .refr_tick(refr_tick), .btn_start(btn_start), .crash(crash),
    .start_on_i(start_on_i), .start_rom_addr_i(start_rom_addr_i), .start_bit_addr_i(start_bit_addr_i),
    .cnt_on_i(cnt_on_i), .cnt_rom_addr_i(cnt_rom_addr_i), .cnt_bit_addr_i(cnt_bit_addr_i),
    .over_on_i(over_on_i), .over_rom_addr_i(over_rom_addr_i), .over_bit_addr_i(over_bit_addr_i),
    .rom_data(rom_data), .rom_addr(rom_addr), .start_en(start_en), .cnt_en(cnt_en),
    .over_en(over_en), .cnt_digit(cnt_digit), .game_run(game_run), .text_pix(text_pix)
  );

  always #5 clk = ~clk;

  function automatic bit blink_ph(int t);
    return BLINK ? ((t / 30) % 2 == 0) : 1'b1;
  endfunction

  task automatic chk(string nm, int act, int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // one clock: check combinational outputs, advance the model, check registered outputs
  task automatic cyc();
    bit rise;
    int nxt;
    int ea;
    #1;
    ea = over_on_i ? int'(over_rom_addr_i) : cnt_on_i ? int'(cnt_rom_addr_i) : start_on_i ? int'(start_rom_addr_i) : 0;
    chk("rom_addr", int'(rom_addr), ea);
    chk("text_pix", int'(text_pix), m_on ? int'(rom_data[7 - m_bit]) : 0);
    rise = btn_start && !bprev;
    nxt = ms;
    if (reset) nxt = 0;
    else if (ms == 0 && rise) nxt = 1;
    else if (ms == 1 && refr_tick && ent + 1 == 180) nxt = 2;
    else if (ms == 2 && crash) nxt = 3;
    else if (ms == 3 && rise && ent >= 120) nxt = 0;
    ent = (reset || nxt != ms) ? 0 : ent + int'(refr_tick);
    ms = nxt;
    bprev = reset ? 1'b1 : btn_start;
    m_on = reset ? 1'b0 : (over_on_i | cnt_on_i | start_on_i);
    m_bit = reset ? 0 : over_on_i ? int'(over_bit_addr_i) : cnt_on_i ? int'(cnt_bit_addr_i) : int'(start_bit_addr_i);
    @(posedge clk);
    #1;
    chk("start_en", int'(start_en), int'(ms == 0 && blink_ph(ent)));
    chk("cnt_en", int'(cnt_en), int'(ms == 1));
    chk("over_en", int'(over_en), int'(ms == 3 && blink_ph(ent)));
    chk("game_run", int'(game_run), int'(ms == 2));
    chk("cnt_digit", int'(cnt_digit), ms == 1 ? 3 - ent / 60 : 0);
  endtask

  task automatic tick(int n);
    repeat (n) begin
      refr_tick = 1'b1;
      cyc();
      refr_tick = 1'b0;
      cyc();
    end
  endtask

  initial begin
    tbl[0] = '{3'b111, 11'h011, 11'h022, 11'h123, 3'd0, 3'd0, 3'd2, 8'h20, 11'h123, 1'b1};
    tbl[1] = '{3'b111, 11'h011, 11'h022, 11'h123, 3'd0, 3'd0, 3'd2, 8'hDF, 11'h123, 1'b0};
    tbl[2] = '{3'b011, 11'h011, 11'h2AA, 11'h3CC, 3'd1, 3'd7, 3'd4, 8'h01, 11'h2AA, 1'b1};
    tbl[3] = '{3'b001, 11'h7FF, 11'h155, 11'h0F0, 3'd0, 3'd6, 3'd5, 8'h80, 11'h7FF, 1'b1};
    tbl[4] = '{3'b000, 11'h444, 11'h555, 11'h666, 3'd1, 3'd2, 3'd3, 8'hFF, 11'h000, 1'b0};
    tbl[5] = '{3'b010, 11'h001, 11'h055, 11'h002, 3'd1, 3'd3, 3'd4, 8'hEF, 11'h055, 1'b0};

    reset = 1'b1;
    btn_start = 1'b1;
    @(posedge clk);
    #1;
    cyc();
    chk("rst_start_en", int'(start_en), 1);
    chk("rst_text_pix", int'(text_pix), 0);
    reset = 1'b0;
    tick(5);
    chk("held_btn_no_count", int'(cnt_en), 0);
    chk("held_btn_start_en", int'(start_en), int'(blink_ph(5)));

    reset = 1'b1;
    btn_start = 1'b0;
    cyc();
    reset = 1'b0;
    tick(30);
    chk("blink_off", int'(start_en), BLINK ? 0 : 1);
    tick(30);
    chk("blink_on", int'(start_en), 1);

    btn_start = 1'b1;
    cyc();
    chk("digit3", int'(cnt_digit), 3);
    btn_start = 1'b0;
    tick(60);
    chk("digit2", int'(cnt_digit), 2);
    tick(60);
    chk("digit1", int'(cnt_digit), 1);
    tick(59);
    chk("not_run_yet", int'(game_run), 0);
    tick(1);
    chk("run", int'(game_run), 1);
    chk("run_digit0", int'(cnt_digit), 0);

    crash = 1'b1;
    btn_start = 1'b1;
    cyc();
    chk("crash_wins_over", int'(over_en), 1);
    chk("crash_wins_run", int'(game_run), 0);
    crash = 1'b0;
    btn_start = 1'b0;
    cyc();

    tick(119);
    btn_start = 1'b1;
    cyc();
    chk("over_early_ignored", int'(start_en), 0);
    btn_start = 1'b0;
    cyc();
    tick(1);
    btn_start = 1'b1;
    cyc();
    chk("over_restart_idle", int'(start_en), 1);
    chk("over_restart_over_en", int'(over_en), 0);
    btn_start = 1'b0;
    cyc();

    foreach (tbl[i]) begin
      {over_on_i, cnt_on_i, start_on_i} = tbl[i].on;
      start_rom_addr_i = tbl[i].sa;
      cnt_rom_addr_i = tbl[i].ca;
      over_rom_addr_i = tbl[i].oa;
      start_bit_addr_i = tbl[i].sb;
      cnt_bit_addr_i = tbl[i].cb;
      over_bit_addr_i = tbl[i].ob;
      rom_data = 8'h00;
      #1;
      chk($sformatf("tbl%0d_addr", i), int'(rom_addr), int'(tbl[i].ea));
      cyc();
      {over_on_i, cnt_on_i, start_on_i} = 3'b000;
      rom_data = tbl[i].rd;
      #1;
      chk($sformatf("tbl%0d_pix", i), int'(text_pix), int'(tbl[i].ep));
      cyc();
    end

    repeat (6000) begin
      reset = $urandom_range(0, 1999) == 0;
      refr_tick = $urandom_range(0, 1) == 0;
      if ($urandom_range(0, 15) == 0) btn_start = ~btn_start;
      crash = $urandom_range(0, 63) == 0;
      {over_on_i, cnt_on_i, start_on_i} = 3'($urandom);
      start_rom_addr_i = 11'($urandom);
      cnt_rom_addr_i = 11'($urandom);
      over_rom_addr_i = 11'($urandom);
      start_bit_addr_i = 3'($urandom);
      cnt_bit_addr_i = 3'($urandom);
      over_bit_addr_i = 3'($urandom);
      rom_data = 8'($urandom);
      cyc();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
